// File: rtl/nasti_stream_demux_if.sv
// NASTI/AXI-Stream channel: one valid/ready beat carrying the full payload.
// The master drives the payload and t_valid; the slave returns t_ready.
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic                      t_last;
    logic [ID_WIDTH-1:0]       t_id;
    logic [DEST_WIDTH-1:0]     t_dest;
    logic [USER_WIDTH-1:0]     t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last,
        output t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last,
        input  t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_demux.sv
// Packet demultiplexer: routes each stream packet to slave[t_dest] through a
// one-entry output register; packets to a non-existent port are dropped and counted.
module nasti_stream_demux #(
    parameter int DEST_WIDTH = 1,
    parameter int N_PORT     = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    nasti_stream_channel.slave   master,
    nasti_stream_channel.master  slave [N_PORT],
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 busy
);
    localparam int NSEL = 2 ** DEST_WIDTH;
    localparam logic [DEST_WIDTH:0] LP_NPORT = (DEST_WIDTH+1)'(N_PORT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEST_WIDTH-1:0]   r_sel;
    logic                    r_out_valid;
    logic [DEST_WIDTH-1:0]   r_out_sel;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [DATA_WIDTH/8-1:0] r_keep;
    logic                    r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic [USER_WIDTH-1:0]   r_user;
    logic [CNT_WIDTH-1:0]    r_drop_cnt;

    logic [NSEL-1:0]         w_rdy;
    logic                    w_out_rdy;
    logic                    w_m_ready;
    logic                    w_legal;
    logic                    w_load;
    logic                    w_drop_last;

    // Ready vector padded to the full t_dest range so out_sel indexes it directly.
    for (genvar g = 0; g < NSEL; g++) begin : g_rdy
        if (g < N_PORT) begin : g_act
            assign w_rdy[g] = slave[g].t_ready;
        end else begin : g_nc
            assign w_rdy[g] = 1'b0;
        end
    end

    for (genvar g = 0; g < N_PORT; g++) begin : g_out
        assign slave[g].t_valid = r_out_valid
                                && (r_out_sel == DEST_WIDTH'(g));
        assign slave[g].t_data  = r_data;
        assign slave[g].t_strb  = r_strb;
        assign slave[g].t_keep  = r_keep;
        assign slave[g].t_last  = r_last;
        assign slave[g].t_id    = r_id;
        assign slave[g].t_dest  = r_dest;
        assign slave[g].t_user  = r_user;
    end

    assign w_out_rdy = w_rdy[r_out_sel];
    assign w_legal   = {1'b0, master.t_dest} < LP_NPORT;

    always_comb begin
        w_state_nxt = r_state;
        w_m_ready   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (master.t_valid)
                    w_state_nxt = w_legal ? ST_ROUTE : ST_DROP;
            end
            ST_ROUTE: begin
                w_m_ready = !r_out_valid || w_out_rdy;
                if (w_m_ready && master.t_valid && master.t_last)
                    w_state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                w_m_ready = 1'b1;
                if (master.t_valid && master.t_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load      = (r_state == ST_ROUTE) && master.t_valid && w_m_ready;
    assign w_drop_last = (r_state == ST_DROP) && master.t_valid
                       && master.t_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && master.t_valid)
                r_sel <= master.t_dest;
            if (w_drop_last && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // out_sel travels with the beat, so a newly latched sel cannot redirect it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_data      <= '0;
            r_strb      <= '0;
            r_keep      <= '0;
            r_last      <= 1'b0;
            r_id        <= '0;
            r_dest      <= '0;
            r_user      <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= r_sel;
            r_data      <= master.t_data;
            r_strb      <= master.t_strb;
            r_keep      <= master.t_keep;
            r_last      <= master.t_last;
            r_id        <= master.t_id;
            r_dest      <= master.t_dest;
            r_user      <= master.t_user;
        end else if (r_out_valid && w_out_rdy) begin
            r_out_valid <= 1'b0;
        end
    end

    assign master.t_ready = w_m_ready;
    assign drop_cnt       = r_drop_cnt;
    assign busy           = (r_state != ST_IDLE) || r_out_valid;
endmodule
